// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and sizing helper for the serial binary-to-BCD engine.
package bcd_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned CORR_THRESH = 5;
    localparam int unsigned CORR_ADD    = 3;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

    // Smallest digit count D with 10^D > 2^bin_w (valid for bin_w up to 60).
    function automatic int unsigned min_digits(input int unsigned bin_w);
        longint unsigned lim;
        longint unsigned p;
        int unsigned     d;
        lim = 64'(1) << bin_w;
        p   = 64'(1);
        d   = 0;
        while (p <= lim) begin
            p = p * 64'(10);
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Request/result bundle between the producers, the shared BCD engine and the display consumer.
interface bcd_conv_sched_if #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*BIN_W-1:0] req_bin;
    logic [N_REQ-1:0]       req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [ID_W-1:0]        res_id;
    logic [4*DIGITS-1:0]    res_bcd;
    logic                   busy;

    modport master (
        output req_valid, req_bin, res_ready,
        input  req_ready, res_valid, res_id, res_bcd, busy
    );

    modport slave (
        input  req_valid, req_bin, res_ready,
        output req_ready, res_valid, res_id, res_bcd, busy
    );
endinterface

// File: rtl/bcd_conv_sched_dabble_step.sv
// One double-dabble iteration: per-digit add-3 correction, then shift in one serial bit.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 5
) (
    input  logic [DIGIT_W*DIGITS-1:0] digits,
    input  logic                      bit_in,
    output logic [DIGIT_W*DIGITS-1:0] digits_next
);
    localparam int unsigned BCD_W = DIGIT_W * DIGITS;

    logic [BCD_W-1:0] corr;

    // Correction is local to each nibble; no carry crosses digit boundaries.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [DIGIT_W-1:0] d;
        assign d = digits[i*DIGIT_W +: DIGIT_W];
        assign corr[i*DIGIT_W +: DIGIT_W] =
            (d >= DIGIT_W'(CORR_THRESH)) ? d + DIGIT_W'(CORR_ADD) : d;
    end

    assign digits_next = (corr << 1) | {{(BCD_W-1){1'b0}}, bit_in};

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler in front of a single time-shared serial binary-to-BCD converter.
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input logic              clk,
    input logic              rst_n,
    bcd_conv_sched_if.slave  bus
);
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = DIGIT_W * DIGITS;

    if (DIGITS < min_digits(BIN_W)) begin : g_digits_chk
        $error("bcd_conv_sched: DIGITS too small for BIN_W");
    end
    if (N_REQ < 2 || N_REQ > 4) begin : g_nreq_chk
        $error("bcd_conv_sched: N_REQ must be 2..4");
    end

    logic [ST_W-1:0]  state_q,     state_nxt;
    logic [CNT_W-1:0] cnt_q,       cnt_nxt;
    logic [BIN_W-1:0] opnd_q,      opnd_nxt;
    logic [BCD_W-1:0] digits_q,    digits_nxt;
    logic [ID_W-1:0]  id_q,        id_nxt;
    logic [ID_W-1:0]  last_q,      last_nxt;
    logic             res_valid_q, res_valid_nxt;
    logic [BCD_W-1:0] res_bcd_q,   res_bcd_nxt;
    logic [ID_W-1:0]  res_id_q,    res_id_nxt;
    logic             busy_q,      busy_nxt;

    logic             arb_any;
    logic [ID_W-1:0]  arb_win;
    logic [ID_W-1:0]  arb_idx;
    logic [BIN_W-1:0] opnd_sel;
    logic [BCD_W-1:0] step_out;
    logic [N_REQ-1:0] gnt_c;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        arb_any = 1'b0;
        arb_win = '0;
        arb_idx = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            arb_idx = ID_W'((32'(last_q) + i) % N_REQ);
            if (!arb_any && bus.req_valid[arb_idx]) begin
                arb_any = 1'b1;
                arb_win = arb_idx;
            end
        end
    end

    always_comb begin
        opnd_sel = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (arb_win == ID_W'(k)) opnd_sel = bus.req_bin[k*BIN_W +: BIN_W];
        end
    end

    assign gnt_c = (rst_n && state_q == ST_IDLE && arb_any) ? (N_REQ'(1) << arb_win) : '0;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .digits      (digits_q),
        .bit_in      (opnd_q[BIN_W-1]),
        .digits_next (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opnd_q      <= '0;
            digits_q    <= '0;
            id_q        <= '0;
            last_q      <= ID_W'(N_REQ - 1);
            res_valid_q <= 1'b0;
            res_bcd_q   <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            opnd_q      <= opnd_nxt;
            digits_q    <= digits_nxt;
            id_q        <= id_nxt;
            last_q      <= last_nxt;
            res_valid_q <= res_valid_nxt;
            res_bcd_q   <= res_bcd_nxt;
            res_id_q    <= res_id_nxt;
            busy_q      <= busy_nxt;
        end
    end

    // Load happens on the grant edge; results are published only when entering DONE.
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        opnd_nxt      = opnd_q;
        digits_nxt    = digits_q;
        id_nxt        = id_q;
        last_nxt      = last_q;
        res_valid_nxt = res_valid_q;
        res_bcd_nxt   = res_bcd_q;
        res_id_nxt    = res_id_q;
        busy_nxt      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    opnd_nxt   = opnd_sel;
                    digits_nxt = '0;
                    cnt_nxt    = '0;
                    id_nxt     = arb_win;
                    last_nxt   = arb_win;
                    busy_nxt   = 1'b1;
                    state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                digits_nxt = step_out;
                opnd_nxt   = {opnd_q[BIN_W-2:0], 1'b0};
                cnt_nxt    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_nxt     = ST_DONE;
                    res_valid_nxt = 1'b1;
                    res_bcd_nxt   = step_out;
                    res_id_nxt    = id_q;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_nxt     = ST_IDLE;
                    res_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready = gnt_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_bcd   = res_bcd_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = busy_q;

endmodule
